// File: rtl/execute_stage_pkg.sv
// Shared cpu constants: data-processing opcodes, condition codes and NZCV bit positions.
package execute_stage_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_RSB = 4'b0011,
        OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_RSC = 4'b0111,
        OP_TST = 4'b1000, OP_TEQ = 4'b1001, OP_CMP = 4'b1010, OP_CMN = 4'b1011,
        OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_BIC = 4'b1110, OP_MVN = 4'b1111
    } opcode_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'b0000, CC_NE = 4'b0001, CC_CS = 4'b0010, CC_CC = 4'b0011,
        CC_MI = 4'b0100, CC_PL = 4'b0101, CC_VS = 4'b0110, CC_VC = 4'b0111,
        CC_HI = 4'b1000, CC_LS = 4'b1001, CC_GE = 4'b1010, CC_LT = 4'b1011,
        CC_GT = 4'b1100, CC_LE = 4'b1101, CC_AL = 4'b1110, CC_NV = 4'b1111
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    // Compare/test opcodes update flags unconditionally and never write a register.
    function automatic logic is_test_op(input logic [3:0] op);
        return op[3:2] == 2'b10;
    endfunction

endpackage

// File: rtl/execute_stage_cond_eval.sv
// ARM condition-field evaluator: decides whether an instruction executes given NZCV.
module cond_eval
    import execute_stage_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);

    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Map each condition code onto its flag predicate.
    always_comb begin
        // NOTE: assigning a default before the case keeps this purely combinational (no latch).
        pass = 1'b0;
        case (cond)
            CC_EQ:   pass = z;
            CC_NE:   pass = !z;
            CC_CS:   pass = c;
            CC_CC:   pass = !c;
            CC_MI:   pass = n;
            CC_PL:   pass = !n;
            CC_VS:   pass = v;
            CC_VC:   pass = !v;
            CC_HI:   pass = c && !z;
            CC_LS:   pass = !c || z;
            CC_GE:   pass = n == v;
            CC_LT:   pass = n != v;
            CC_GT:   pass = !z && (n == v);
            CC_LE:   pass = z || (n != v);
            CC_AL:   pass = 1'b1;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand bypass, ALU, condition check, registered write port and NZCV.
module execute_stage
    import execute_stage_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        valid_i,
    input  logic        flush_i,
    input  logic [3:0]  opcode_i,
    input  logic [3:0]  cond_i,
    input  logic        set_flags_i,
    input  logic [3:0]  rd_i,
    input  logic [3:0]  a_addr_i,
    input  logic [3:0]  b_addr_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        wr_en_o,
    output logic [3:0]  wr_addr_o,
    output logic [31:0] wr_data_o,
    output logic [3:0]  flags_o
);

    // Write seen one cycle earlier, so a bubble between producer and consumer still bypasses.
    logic        lw_valid;
    logic [3:0]  lw_addr;
    logic [31:0] lw_data;

    logic        cond_pass;
    logic        execute;
    logic        do_write;
    logic        do_flags;
    logic [31:0] eff_a, eff_b;
    logic [31:0] add_x, add_y;
    logic        add_cin;
    logic [32:0] sum;
    logic        is_arith;
    logic [31:0] logic_res;
    logic [31:0] result;
    logic [3:0]  new_flags;

    cond_eval u_cond_eval (
        .cond (cond_i),
        .nzcv (flags_o),
        .pass (cond_pass)
    );

    assign execute  = valid_i && !flush_i && cond_pass;
    assign do_write = execute && !is_test_op(opcode_i);
    assign do_flags = execute && (is_test_op(opcode_i) || set_flags_i);

    // Operand bypass: the write port (newest) beats the last-write register, which beats the file.
    always_comb begin
        eff_a = a_i;
        if (wr_en_o && wr_addr_o == a_addr_i)       eff_a = wr_data_o;
        else if (lw_valid && lw_addr == a_addr_i)   eff_a = lw_data;
        eff_b = b_i;
        if (wr_en_o && wr_addr_o == b_addr_i)       eff_b = wr_data_o;
        else if (lw_valid && lw_addr == b_addr_i)   eff_b = lw_data;
    end

    // Select adder operands / logical result per opcode; subtract forms invert one side.
    always_comb begin
        add_x     = eff_a;
        add_y     = ~eff_b;
        add_cin   = 1'b1;
        is_arith  = 1'b1;
        logic_res = '0;
        case (opcode_e'(opcode_i))
            OP_SUB, OP_CMP: ;
            OP_RSB:         begin add_x = eff_b; add_y = ~eff_a; end
            OP_ADD, OP_CMN: begin add_y = eff_b; add_cin = 1'b0; end
            OP_ADC:         begin add_y = eff_b; add_cin = flags_o[FLAG_C]; end
            OP_SBC:         add_cin = flags_o[FLAG_C];
            OP_RSC:         begin add_x = eff_b; add_y = ~eff_a; add_cin = flags_o[FLAG_C]; end
            OP_AND, OP_TST: begin is_arith = 1'b0; logic_res = eff_a & eff_b; end
            OP_EOR, OP_TEQ: begin is_arith = 1'b0; logic_res = eff_a ^ eff_b; end
            OP_ORR:         begin is_arith = 1'b0; logic_res = eff_a | eff_b; end
            OP_MOV:         begin is_arith = 1'b0; logic_res = eff_b; end
            OP_BIC:         begin is_arith = 1'b0; logic_res = eff_a & ~eff_b; end
            OP_MVN:         begin is_arith = 1'b0; logic_res = ~eff_b; end
            default: ;
        endcase
    end

    assign sum    = {1'b0, add_x} + {1'b0, add_y} + {32'd0, add_cin};
    assign result = is_arith ? sum[31:0] : logic_res;

    // Logical ops leave C and V alone; V is overflow of the addition actually performed.
    always_comb begin
        new_flags         = flags_o;
        new_flags[FLAG_N] = result[31];
        new_flags[FLAG_Z] = (result == 32'd0);
        if (is_arith) begin
            new_flags[FLAG_C] = sum[32];
            new_flags[FLAG_V] = (add_x[31] == add_y[31]) && (sum[31] != add_x[31]);
        end
    end

    // Register the write port, flags and last-write copy; reset discards anything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_en_o   <= 1'b0;
            wr_addr_o <= '0;
            wr_data_o <= '0;
            flags_o   <= '0;
            lw_valid  <= 1'b0;
            lw_addr   <= '0;
            lw_data   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            wr_en_o <= do_write;
            if (do_write) begin
                wr_addr_o <= rd_i;
                wr_data_o <= result;
            end
            if (do_flags) flags_o <= new_flags;
            lw_valid <= wr_en_o;
            lw_addr  <= wr_addr_o;
            lw_data  <= wr_data_o;
        end
    end

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: driver queues expected write-port/flag state,
// a monitor compares one cycle later.
module tb_execute_stage;
    import execute_stage_pkg::*;

    typedef struct {
        string       name;
        logic        en;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [3:0]  flags;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [3:0]  opcode_i = '0;
    logic [3:0]  cond_i = '0;
    logic        set_flags_i = 1'b0;
    logic [3:0]  rd_i = '0;
    logic [3:0]  a_addr_i = '0;
    logic [3:0]  b_addr_i = '0;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        wr_en_o;
    logic [3:0]  wr_addr_o;
    logic [31:0] wr_data_o;
    logic [3:0]  flags_o;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_passed = 0;

    always #5 clk_i = ~clk_i;

    execute_stage dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .valid_i     (valid_i),
        .flush_i     (flush_i),
        .opcode_i    (opcode_i),
        .cond_i      (cond_i),
        .set_flags_i (set_flags_i),
        .rd_i        (rd_i),
        .a_addr_i    (a_addr_i),
        .b_addr_i    (b_addr_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .wr_en_o     (wr_en_o),
        .wr_addr_o   (wr_addr_o),
        .wr_data_o   (wr_data_o),
        .flags_o     (flags_o)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // Drive one instruction slot at the falling edge and queue its expected outcome.
    task automatic issue(input string name, input logic v, input logic f, input logic [3:0] op,
                         input logic [3:0] cc, input logic s, input logic [3:0] rd,
                         input logic [3:0] aa, input logic [3:0] ba,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic e_en, input logic [3:0] e_addr,
                         input logic [31:0] e_data, input logic [3:0] e_flags);
        exp_t e;
        @(negedge clk_i);
        valid_i = v; flush_i = f; opcode_i = op; cond_i = cc; set_flags_i = s;
        rd_i = rd; a_addr_i = aa; b_addr_i = ba; a_i = a; b_i = b;
        e.name = name; e.en = e_en; e.addr = e_addr; e.data = e_data; e.flags = e_flags;
        sb_q.push_back(e);
    endtask

    // Monitor: compare the registered outputs just after each rising edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk_i);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check({e.name, ".wr_en"},   {31'd0, wr_en_o}, {31'd0, e.en});
                check({e.name, ".wr_addr"}, {28'd0, wr_addr_o}, {28'd0, e.addr});
                check({e.name, ".wr_data"}, wr_data_o, e.data);
                check({e.name, ".flags"},   {28'd0, flags_o}, {28'd0, e.flags});
            end
        end
    end

    initial begin
        #12;
        check("reset.wr_en",   {31'd0, wr_en_o}, 32'd0);
        check("reset.wr_addr", {28'd0, wr_addr_o}, 32'd0);
        check("reset.wr_data", wr_data_o, 32'd0);
        check("reset.flags",   {28'd0, flags_o}, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        //     name         v  f  op      cond   s  rd  aa  ba  a             b             en addr data          nzcv
        issue("adds_basic", 1, 0, OP_ADD, CC_AL, 1, 2,  0,  1,  32'd5,        32'd7,        1, 2,  32'd12,       4'b0000);
        issue("cmp_eq",     1, 0, OP_CMP, CC_AL, 0, 0,  6,  7,  32'd3,        32'd3,        0, 2,  32'd12,       4'b0110);
        issue("addeq",      1, 0, OP_ADD, CC_EQ, 0, 4,  8,  9,  32'd1,        32'd2,        1, 4,  32'd3,        4'b0110);
        issue("addne",      1, 0, OP_ADD, CC_NE, 0, 5,  8,  9,  32'd1,        32'd2,        0, 4,  32'd3,        4'b0110);
        issue("adds_ovf",   1, 0, OP_ADD, CC_AL, 1, 6,  10, 11, 32'h7FFFFFFF, 32'd1,        1, 6,  32'h80000000, 4'b1001);
        issue("movs_zero",  1, 0, OP_MOV, CC_AL, 1, 7,  14, 12, 32'd0,        32'd0,        1, 7,  32'd0,        4'b0101);
        issue("mov_r3",     1, 0, OP_MOV, CC_AL, 0, 3,  14, 13, 32'd0,        32'd9,        1, 3,  32'd9,        4'b0101);
        issue("byp_wr",     1, 0, OP_ADD, CC_AL, 0, 5,  3,  3,  32'd0,        32'd0,        1, 5,  32'd18,       4'b0101);
        issue("mov_r3_b",   1, 0, OP_MOV, CC_AL, 0, 3,  14, 13, 32'd0,        32'd9,        1, 3,  32'd9,        4'b0101);
        issue("bubble",     0, 0, OP_ADD, CC_AL, 1, 8,  0,  0,  32'd0,        32'd0,        0, 3,  32'd9,        4'b0101);
        issue("byp_lw",     1, 0, OP_ADD, CC_AL, 0, 5,  3,  3,  32'd0,        32'd0,        1, 5,  32'd18,       4'b0101);
        issue("flush_wins", 1, 1, OP_ADD, CC_AL, 1, 8,  1,  2,  32'd1,        32'd1,        0, 5,  32'd18,       4'b0101);
        issue("cond_never", 1, 0, OP_ADD, CC_NV, 1, 8,  1,  2,  32'd1,        32'd1,        0, 5,  32'd18,       4'b0101);
        issue("subs_borr",  1, 0, OP_SUB, CC_AL, 1, 9,  1,  2,  32'd3,        32'd5,        1, 9,  32'hFFFFFFFE, 4'b1000);
        issue("addlt",      1, 0, OP_ADD, CC_LT, 0, 10, 1,  2,  32'd1,        32'd1,        1, 10, 32'd2,        4'b1000);
        issue("rsbs",       1, 0, OP_RSB, CC_AL, 1, 11, 1,  2,  32'd2,        32'd10,       1, 11, 32'd8,        4'b0010);
        issue("teq",        1, 0, OP_TEQ, CC_AL, 0, 0,  1,  2,  32'd5,        32'd5,        0, 11, 32'd8,        4'b0110);
        issue("adcs",       1, 0, OP_ADC, CC_AL, 1, 12, 1,  2,  32'd1,        32'd1,        1, 12, 32'd3,        4'b0000);
        issue("subs_pre",   1, 0, OP_SUB, CC_AL, 1, 13, 1,  2,  32'd1,        32'd2,        1, 13, 32'hFFFFFFFF, 4'b1000);

        // Reset pulsed while the last write is visible on the port.
        @(posedge clk_i);
        #3;
        valid_i = 1'b0;
        rst_ni  = 1'b0;
        #1;
        check("async_rst.wr_en",   {31'd0, wr_en_o}, 32'd0);
        check("async_rst.wr_addr", {28'd0, wr_addr_o}, 32'd0);
        check("async_rst.wr_data", wr_data_o, 32'd0);
        check("async_rst.flags",   {28'd0, flags_o}, 32'd0);
        check("sb_drained",        sb_q.size(), 32'd0);
        @(negedge clk_i);
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk_i);
            #1;
            check("post_rst.wr_en",   {31'd0, wr_en_o}, 32'd0);
            check("post_rst.wr_data", wr_data_o, 32'd0);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #20000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/execute_stage.md
EXECUTE_STAGE -- requirements
Module: execute_stage

Interface
REQ-001 SHALL have ports: clk_i input 1, the single clock, all state on rising edge.
REQ-002 SHALL have rst_ni input 1, reset, asynchronous assert, active-low.
REQ-003 SHALL have valid_i input 1: instruction present this cycle, aligned with operands arriving one clock after the register-file read address.
REQ-004 SHALL have flush_i input 1: kill the instruction presented this cycle.
REQ-005 SHALL have opcode_i input 4: ARM data-processing opcode (AND, EOR, SUB, RSB, ADD, ADC, SBC, RSC, TST, TEQ, CMP, CMN, ORR, MOV, BIC, MVN; 0000..1111).
REQ-006 SHALL have cond_i input 4: ARM condition field (EQ..AL, 1111 = never).
REQ-007 SHALL have set_flags_i input 1: S bit.
REQ-008 SHALL have rd_i, a_addr_i, b_addr_i inputs 4 each: destination and source register numbers.
REQ-009 SHALL have a_i, b_i inputs 32 each: register-file read data.
REQ-010 SHALL have wr_en_o output 1, wr_addr_o output 4, wr_data_o output 32: register-file write port, registered.
REQ-011 SHALL have flags_o output 4: current NZCV (bit3 N .. bit0 V), registered.

Function
REQ-012 An instruction issues when valid_i=1 and flush_i=0; it executes when it issues and cond_i passes against the current flags_o.
REQ-013 Condition pass SHALL follow ARM semantics: EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V, HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V), AL 1, 1111 0.
REQ-014 Operand bypass: effective A = wr_data_o if wr_en_o and wr_addr_o==a_addr_i; else last-write data if last-write valid and address matches; else a_i. Same for B. Newest write wins.
REQ-015 Last-write register SHALL capture {wr_en_o, wr_addr_o, wr_data_o} every clock.
REQ-016 Arithmetic: 33-bit add; SUB A+~B+1, RSB B+~A+1, ADC A+B+C, SBC A+~B+C, RSC B+~A+C, CMP as SUB, CMN as ADD; C = carry-out (SUB forms: C = NOT borrow).
REQ-017 V SHALL be signed overflow of the performed addition (operand signs equal, result sign differs).
REQ-018 Logical ops (AND, EOR, TST, TEQ, ORR, MOV=B, BIC=A&~B, MVN=~B) SHALL update N, Z only; C, V unchanged.
REQ-019 N = result[31]; Z = (result==0).
REQ-020 Executed TST, TEQ, CMP, CMN SHALL update flags regardless of set_flags_i and SHALL NOT write.
REQ-021 Other executed opcodes SHALL write: on the next rising edge wr_en_o=1, wr_addr_o=rd_i, wr_data_o=result (latency 1); flags updated on the same edge only if set_flags_i=1.
REQ-022 Non-issued or condition-failed instructions: wr_en_o=0 next cycle, flags unchanged; wr_addr_o/wr_data_o SHALL hold their previous values.
REQ-023 Back-to-back: condition of instruction N+1 SHALL see flags written by instruction N.
REQ-024 flush_i and valid_i both high: flush wins.
REQ-025 rd_i=15 SHALL be treated as an ordinary register write.

Reset
REQ-026 rst_ni low SHALL immediately force wr_en_o=0, wr_addr_o=0, wr_data_o=0, flags_o=0000, last-write cleared.
REQ-027 Reset asserted mid-operation SHALL discard the in-flight write; first issue allowed on first rising edge after deassertion.

Structure
REQ-028 Opcode and condition encodings and NZCV bit indices SHALL be constants in the shared cpu package.
REQ-029 Condition evaluation SHALL be a combinational sub-module cond_eval (cond, NZCV -> pass).

Verification
REQ-030 ADD r2=r0(5)+r1(7), S=1, AL -> next cycle wr_en_o=1, wr_addr_o=2, wr_data_o=12, flags 0000.
REQ-031 CMP a=3,b=3 then ADDEQ r4 -> flags 0110 (Z,C); second instruction writes; ADDNE instead -> wr_en_o=0.
REQ-032 ADDS 0x7FFFFFFF+1 -> data 0x80000000, flags 1001; then MOVS b=0 -> flags 0101 (C,V preserved, Z set).
REQ-033 MOV r3=9 followed immediately by ADD r5=r3+r3 with stale a_i=b_i=0 -> wr_data_o=18; one bubble between -> still 18 via last-write bypass.
REQ-034 valid_i=1 with flush_i=1, or cond 1111 -> no write, flags unchanged.
REQ-035 rst_ni pulsed low while wr_en_o=1 -> outputs 0 asynchronously, no write after release.
